// File: rtl/svreal_rec_pkg.sv
// svreal_rec_pkg: recoded-float class encodings, status flag indices and exponent bias helper
package svreal_rec_pkg;
    localparam logic [2:0] REC_ZERO = 3'b000;
    localparam logic [2:0] REC_INF  = 3'b110;
    localparam logic [2:0] REC_NAN  = 3'b111;
    localparam int FLAG_NAN     = 3;
    localparam int FLAG_OVF     = 2;
    localparam int FLAG_UNF     = 1;
    localparam int FLAG_INEXACT = 0;
    typedef enum logic [1:0] {CLS_ZERO, CLS_FIN, CLS_INF, CLS_NAN} rec_cls_t;
    function automatic int rec_bias(input int exp_width);
        return 1 << exp_width;
    endfunction
endpackage

// File: rtl/svreal_rec_classify.sv
// svreal_rec_classify: combinational decode of a recoded float into class, sign,
// unbiased exponent and significand with hidden bit
module svreal_rec_classify import svreal_rec_pkg::*; #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0]  in_data,
    output rec_cls_t                      cls,
    output logic                          sgn,
    output logic signed [EXP_WIDTH+1:0]   exp_unb,
    output logic [SIG_WIDTH-1:0]          sig
);
    logic [EXP_WIDTH:0] exp_rec;
    logic [2:0]         top3;
    always_comb begin
        exp_rec = in_data[EXP_WIDTH+SIG_WIDTH-1:SIG_WIDTH-1];
        top3    = exp_rec[EXP_WIDTH:EXP_WIDTH-2];
        sgn     = in_data[EXP_WIDTH+SIG_WIDTH];
        sig     = {1'b1, in_data[SIG_WIDTH-2:0]};
        exp_unb = $signed({1'b0, exp_rec}) - $signed((EXP_WIDTH+2)'(rec_bias(EXP_WIDTH)));
        cls     = top3 == REC_ZERO ? CLS_ZERO :
                  top3 == REC_INF  ? CLS_INF  :
                  top3 == REC_NAN  ? CLS_NAN  : CLS_FIN;
    end
endmodule

// File: rtl/svreal_rec2fix_pipe.sv
// svreal_rec2fix_pipe: 3-stage recoded-float to signed fixed-point converter with valid/ready.
// Define SVREAL_REC2FIX_ROUND_EN for round-to-nearest-ties-away instead of truncation.
module svreal_rec2fix_pipe import svreal_rec_pkg::*; #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int OUT_WIDTH = 32,
    parameter int OUT_EXP   = -16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [3:0]                   out_flags,
    output logic                         out_valid,
    input  logic                         out_ready
);
    // sig is placed so that bit SIG_WIDTH+1 of the shifted word has weight 2^OUT_EXP
    localparam int AMAX = SIG_WIDTH + OUT_WIDTH + 2;
    localparam int SHW  = $clog2(AMAX + 1);
    localparam int TW   = SIG_WIDTH + AMAX;
    localparam logic [OUT_WIDTH-1:0] MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`ifdef SVREAL_REC2FIX_ROUND_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    rec_cls_t                     c_cls, cls1_d, cls1_q, cls2_d, cls2_q;
    logic                         c_sgn, sgn1_d, sgn1_q, sgn2_d, sgn2_q;
    logic signed [EXP_WIDTH+1:0]  c_exp;
    logic [SIG_WIDTH-1:0]         c_sig, sig1_d, sig1_q;
    logic [SHW-1:0]               sh1_d, sh1_q;
    logic                         v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
    logic [OUT_WIDTH:0]           mag2_d, mag2_q;
    logic                         big2_d, big2_q, g2_d, g2_q, st2_d, st2_q;
    logic [OUT_WIDTH-1:0]         out_data_d, out_data_q;
    logic [3:0]                   out_flags_d, out_flags_q;
    logic [TW-1:0]                wide;
    logic [OUT_WIDTH+1:0]         magr;
    logic [OUT_WIDTH-1:0]         trunc, val, sat;
    logic                         en, fin, ovf, zero_r;
    int                           a_raw;

    svreal_rec_classify #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls (
        .in_data (in_data),
        .cls     (c_cls),
        .sgn     (c_sgn),
        .exp_unb (c_exp),
        .sig     (c_sig)
    );

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        a_raw  = int'(c_exp) - OUT_EXP + 2;
        v1_d   = in_valid;
        cls1_d = c_cls;
        sgn1_d = c_sgn;
        sig1_d = c_sig;
        sh1_d  = a_raw < 0 ? '0 : a_raw > AMAX ? SHW'(AMAX) : SHW'(a_raw);
        wide   = TW'(sig1_q) << sh1_q;
        v2_d   = v1_q;
        cls2_d = cls1_q;
        sgn2_d = sgn1_q;
        big2_d = |wide[TW-1:SIG_WIDTH+OUT_WIDTH+2];
        mag2_d = wide[SIG_WIDTH+OUT_WIDTH+1:SIG_WIDTH+1];
        g2_d   = wide[SIG_WIDTH];
        st2_d  = |wide[SIG_WIDTH-1:0];
        magr   = {1'b0, mag2_q} + (OUT_WIDTH+2)'(RND & g2_q);
        fin    = cls2_q == CLS_FIN;
        ovf    = big2_q | (sgn2_q ? (|magr[OUT_WIDTH+1:OUT_WIDTH] | (magr[OUT_WIDTH-1] & |magr[OUT_WIDTH-2:0]))
                                  : |magr[OUT_WIDTH+1:OUT_WIDTH-1]);
        zero_r = !big2_q && magr == '0;
        trunc  = magr[OUT_WIDTH-1:0];
        val    = sgn2_q ? -trunc : trunc;
        sat    = sgn2_q ? MIN_NEG : MAX_POS;
        out_valid_d = v2_q;
        out_data_d  = cls2_q == CLS_ZERO ? '0 :
                      cls2_q == CLS_NAN  ? MAX_POS :
                      cls2_q == CLS_INF  ? sat :
                      ovf                ? sat : val;
        out_flags_d = '0;
        out_flags_d[FLAG_NAN]     = cls2_q == CLS_NAN;
        out_flags_d[FLAG_OVF]     = cls2_q == CLS_INF || (fin && ovf);
        out_flags_d[FLAG_UNF]     = fin && zero_r;
        out_flags_d[FLAG_INEXACT] = fin && (g2_q || st2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            cls1_q      <= CLS_ZERO;
            sgn1_q      <= 1'b0;
            sig1_q      <= '0;
            sh1_q       <= '0;
            v2_q        <= 1'b0;
            cls2_q      <= CLS_ZERO;
            sgn2_q      <= 1'b0;
            mag2_q      <= '0;
            big2_q      <= 1'b0;
            g2_q        <= 1'b0;
            st2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            v1_q        <= v1_d;
            cls1_q      <= cls1_d;
            sgn1_q      <= sgn1_d;
            sig1_q      <= sig1_d;
            sh1_q       <= sh1_d;
            v2_q        <= v2_d;
            cls2_q      <= cls2_d;
            sgn2_q      <= sgn2_d;
            mag2_q      <= mag2_d;
            big2_q      <= big2_d;
            g2_q        <= g2_d;
            st2_q       <= st2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;
endmodule

// File: tb/tb_svreal_rec2fix_pipe.sv
// tb_svreal_rec2fix_pipe: directed vectors with hand-computed expectations for svreal_rec2fix_pipe
module tb_svreal_rec2fix_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic        out_valid;
    logic        out_ready;
    int          n_chk = 0;
    int          n_fail = 0;

    svreal_rec2fix_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // IEEE single fields -> 33-bit recoded word (normal numbers: rec exponent = ieee + 129)
    function automatic logic [32:0] rec(input logic s, input int e, input logic [22:0] f);
        return {s, 9'(e + 129), f};
    endfunction

    task automatic run1(input string tag, input logic [32:0] din, input logic [31:0] ed, input logic [3:0] ef);
        int n;
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check({tag, "_data"}, {32'd0, out_data}, {32'd0, ed});
        check({tag, "_flags"}, {60'd0, out_flags}, {60'd0, ef});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] vec [4];
        int sent, got, seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_flags", {60'd0, out_flags}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        run1("p1_5",    rec(0, 127, 23'h400000), 32'h00018000, 4'b0000);
        run1("m4_56",   rec(1, 129, 23'h11EB85), 32'hFFFB70A4, 4'b0001);
        run1("big",     rec(0, 176, 23'h635FA9), 32'h7FFFFFFF, 4'b0100);
        run1("ninf",    {1'b1, 9'h180, 23'h0},   32'h80000000, 4'b0100);
        run1("pinf",    {1'b0, 9'h180, 23'h0},   32'h7FFFFFFF, 4'b0100);
        run1("nan",     {1'b0, 9'h1C0, 23'h0},   32'h7FFFFFFF, 4'b1000);
        run1("tiny",    rec(0, 107, 23'h0637BD), 32'h00000000, 4'b0011);
        run1("tiniest", rec(0, 1, 23'h0),        32'h00000000, 4'b0011);
        run1("zero",    {1'b0, 9'h000, 23'h0},   32'h00000000, 4'b0000);
        run1("nzero",   {1'b1, 9'h000, 23'h0},   32'h00000000, 4'b0000);
        run1("neg_min", rec(1, 142, 23'h0),      32'h80000000, 4'b0000);
        run1("pos_2p15", rec(0, 142, 23'h0),     32'h7FFFFFFF, 4'b0100);
        run1("pos_near", rec(0, 141, 23'h7FFF00), 32'h7FFF8000, 4'b0000);
`ifdef SVREAL_REC2FIX_ROUND_EN
        run1("half_lsb", rec(0, 127, 23'h000040), 32'h00010001, 4'b0001);
`else
        run1("half_lsb", rec(0, 127, 23'h000040), 32'h00010000, 4'b0001);
`endif

        vec  = '{rec(0, 127, 23'h0), rec(0, 128, 23'h0), rec(0, 128, 23'h400000), rec(0, 129, 23'h0)};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            in_data   = vec[sent < 4 ? sent : 3];
            #1;
            if (c == 4) begin
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold", {32'd0, out_data}, 64'h10000);
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                check($sformatf("b2b_%0d", got), {32'd0, out_data}, 64'(32'h10000 * (got + 1)));
                got++;
            end
        end
        in_valid = 1'b0;
        check("b2b_got", 64'(got), 64'd4);
        check("b2b_sent", 64'(sent), 64'd4);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("b2b_no_dup", 64'(seen), 64'd0);

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_data  = rec(0, 127 + i, 23'h0);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_data", {32'd0, out_data}, 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("post_rst_no_stale", 64'(seen), 64'd0);
        run1("post_rst_1_0", rec(0, 127, 23'h0), 32'h00010000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
